// File: rtl/ssqa_ctrl.sv
// ---------------------------------------------------------------------------
// ssqa_ctrl
//
// Sequencer for the replicated SSQA spin array. Walks every spin of every
// iteration through ITER -> (READ x NN -> DRAIN -> UPD) x N, produces the
// phase enables for the array and the shared xorshift, and ramps the
// annealing schedule (I0, Q) once every TAU iterations with saturation.
// While idle it forwards host J-memory load traffic onto wea/count_*.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start, abort, num_iter   host run control (num_iter latched on start)
//   ld_we, ld_spin, ld_bit   host J-memory load traffic (used in IDLE only)
//   rst_ini, rst_iter        initial / per-iteration reset pulses
//   en_read, en_mult, en_upd memory read, multiply-accumulate, spin update
//   wea                      J-memory write enable (host load)
//   count_spin, count_bit    spin and coupling indices
//   count_iter               iteration index
//   I0, Q                    annealing pseudo-temperature and replica coupling
//   busy, done               run in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module ssqa_ctrl #(
    parameter int N         = 800,
    parameter int NN        = 800,
    parameter int TEM_WIDTH = 8,
    parameter int I0_MIN    = 1,
    parameter int I0_MAX    = 64,
    parameter int I0_STEP   = 1,
    parameter int Q_MIN     = 0,
    parameter int Q_MAX     = 64,
    parameter int Q_STEP    = 1,
    parameter int TAU       = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [15:0]                 num_iter,
    input  logic                        ld_we,
    input  logic [$clog2(NN)-1:0]       ld_spin,
    input  logic [$clog2(NN)-1:0]       ld_bit,
    output logic                        rst_ini,
    output logic                        rst_iter,
    output logic                        en_read,
    output logic                        en_mult,
    output logic                        en_upd,
    output logic                        wea,
    output logic [$clog2(NN)-1:0]       count_spin,
    output logic [$clog2(NN)-1:0]       count_bit,
    output logic [15:0]                 count_iter,
    output logic signed [TEM_WIDTH-1:0] I0,
    output logic signed [TEM_WIDTH-1:0] Q,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = $clog2(NN);
    localparam int SW = (TAU > 1) ? $clog2(TAU) : 1;

    localparam logic [CW-1:0] SPIN_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(NN - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [SW-1:0] SCHED_LAST = SW'(TAU - 1);
    localparam logic [SW-1:0] SCHED_ONE  = SW'(1);

    localparam logic signed [TEM_WIDTH-1:0] I0_INIT = TEM_WIDTH'(I0_MIN);
    localparam logic signed [TEM_WIDTH-1:0] I0_TOP  = TEM_WIDTH'(I0_MAX);
    localparam logic signed [TEM_WIDTH:0]   I0_CEIL = (TEM_WIDTH + 1)'(I0_MAX);
    localparam logic signed [TEM_WIDTH:0]   I0_INC  = (TEM_WIDTH + 1)'(I0_STEP);
    localparam logic signed [TEM_WIDTH-1:0] Q_INIT  = TEM_WIDTH'(Q_MIN);
    localparam logic signed [TEM_WIDTH-1:0] Q_TOP   = TEM_WIDTH'(Q_MAX);
    localparam logic signed [TEM_WIDTH:0]   Q_CEIL  = (TEM_WIDTH + 1)'(Q_MAX);
    localparam logic signed [TEM_WIDTH:0]   Q_INC   = (TEM_WIDTH + 1)'(Q_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_READ,
        S_DRAIN,
        S_UPD,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0]   num_iter_q;
    logic [SW-1:0] sched_cnt;

    logic spin_last;
    logic bit_last;
    logic iter_last;
    logic quit;

    logic rst_ini_nxt;
    logic rst_iter_nxt;
    logic en_read_nxt;
    logic en_upd_nxt;
    logic busy_nxt;
    logic done_nxt;

    logic signed [TEM_WIDTH:0]   i0_sum;
    logic signed [TEM_WIDTH:0]   q_sum;
    logic signed [TEM_WIDTH-1:0] i0_stepped;
    logic signed [TEM_WIDTH-1:0] q_stepped;

    assign spin_last = (count_spin == SPIN_LAST);
    assign bit_last  = (count_bit == BIT_LAST);
    assign iter_last = ((count_iter + 16'd1) == num_iter_q);
    // abort only has an effect once a run is under way
    assign quit      = abort && (state != S_IDLE);

    // Schedule step: sums are one bit wider than I0/Q so the ceiling
    // comparison sees the true value and the result cannot wrap negative.
    always_comb begin
        i0_sum     = $signed({I0[TEM_WIDTH-1], I0}) + I0_INC;
        q_sum      = $signed({Q[TEM_WIDTH-1], Q}) + Q_INC;
        i0_stepped = (i0_sum > I0_CEIL) ? I0_TOP : i0_sum[TEM_WIDTH-1:0];
        q_stepped  = (q_sum > Q_CEIL) ? Q_TOP : q_sum[TEM_WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every transition except out of IDLE,
    // so start beats a simultaneous abort there.
    always_comb begin
        next_state = state;
        if (quit) begin
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  next_state = start ? S_INIT : S_IDLE;
                S_INIT:  next_state = (num_iter_q == 16'd0) ? S_DONE : S_ITER;
                S_ITER:  next_state = S_READ;
                S_READ:  next_state = bit_last ? S_DRAIN : S_READ;
                S_DRAIN: next_state = S_UPD;
                S_UPD: begin
                    if (!spin_last) begin
                        next_state = S_READ;
                    end else begin
                        next_state = iter_last ? S_DONE : S_ITER;
                    end
                end
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered strobes line
    // up with the cycle the FSM actually spends in that state.
    always_comb begin
        rst_ini_nxt  = (next_state == S_INIT);
        rst_iter_nxt = (next_state == S_ITER);
        en_read_nxt  = (next_state == S_READ);
        en_upd_nxt   = (next_state == S_UPD);
        done_nxt     = (next_state == S_DONE);
        busy_nxt     = (next_state != S_IDLE);
    end

    // Strobe registers; en_mult trails en_read by one cycle to cover the
    // memory read latency, and is dropped if the run is aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_ini  <= 1'b0;
            rst_iter <= 1'b0;
            en_read  <= 1'b0;
            en_mult  <= 1'b0;
            en_upd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rst_ini  <= rst_ini_nxt;
            rst_iter <= rst_iter_nxt;
            en_read  <= en_read_nxt;
            en_mult  <= en_read && !quit;
            en_upd   <= en_upd_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Counters, host-load forwarding and annealing schedule. Everything
    // freezes on abort; the IDLE branch then resumes forwarding host traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wea        <= 1'b0;
            count_spin <= '0;
            count_bit  <= '0;
            count_iter <= '0;
            num_iter_q <= '0;
            sched_cnt  <= '0;
            I0         <= I0_INIT;
            Q          <= Q_INIT;
        end else if (state == S_IDLE) begin
            wea        <= ld_we;
            count_spin <= ld_spin;
            count_bit  <= ld_bit;
            if (start) begin
                num_iter_q <= num_iter;
            end
        end else begin
            wea <= 1'b0;
            if (!abort) begin
                case (state)
                    S_INIT: begin
                        count_iter <= '0;
                        sched_cnt  <= '0;
                        I0         <= I0_INIT;
                        Q          <= Q_INIT;
                        if (num_iter_q != 16'd0) begin
                            count_spin <= '0;
                            count_bit  <= '0;
                        end
                    end
                    S_READ: begin
                        if (!bit_last) begin
                            count_bit <= count_bit + CNT_ONE;
                        end
                    end
                    S_UPD: begin
                        if (!spin_last) begin
                            count_spin <= count_spin + CNT_ONE;
                            count_bit  <= '0;
                        end else begin
                            count_iter <= count_iter + 16'd1;
                            if (sched_cnt == SCHED_LAST) begin
                                sched_cnt <= '0;
                                I0        <= i0_stepped;
                                Q         <= q_stepped;
                            end else begin
                                sched_cnt <= sched_cnt + SCHED_ONE;
                            end
                            if (!iter_last) begin
                                count_spin <= '0;
                                count_bit  <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssqa_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssqa_ctrl
//
// Self-checking bench for ssqa_ctrl with a small array (N=4, NN=4) and a
// schedule that saturates (I0 1,3,5,6 and Q 120,125,127 every 2 iterations).
// The reference model derives each cycle's outputs from the cycle's position
// inside the run (iteration, spin, phase) using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ssqa_ctrl;

    localparam int N       = 4;
    localparam int NN      = 4;
    localparam int TW      = 8;
    localparam int I0_MIN  = 1;
    localparam int I0_MAX  = 6;
    localparam int I0_STEP = 2;
    localparam int Q_MIN   = 120;
    localparam int Q_MAX   = 127;
    localparam int Q_STEP  = 5;
    localparam int TAU     = 2;
    localparam int CW      = $clog2(NN);
    localparam int P       = 1 + N * (NN + 2);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [15:0]          num_iter = '0;
    logic                 ld_we = 1'b0;
    logic [CW-1:0]        ld_spin = '0;
    logic [CW-1:0]        ld_bit = '0;
    logic                 rst_ini, rst_iter, en_read, en_mult, en_upd, wea;
    logic [CW-1:0]        count_spin, count_bit;
    logic [15:0]          count_iter;
    logic signed [TW-1:0] I0, Q;
    logic                 busy, done;

    ssqa_ctrl #(
        .N(N), .NN(NN), .TEM_WIDTH(TW),
        .I0_MIN(I0_MIN), .I0_MAX(I0_MAX), .I0_STEP(I0_STEP),
        .Q_MIN(Q_MIN), .Q_MAX(Q_MAX), .Q_STEP(Q_STEP), .TAU(TAU)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_iter(num_iter), .ld_we(ld_we), .ld_spin(ld_spin), .ld_bit(ld_bit),
        .rst_ini(rst_ini), .rst_iter(rst_iter), .en_read(en_read),
        .en_mult(en_mult), .en_upd(en_upd), .wea(wea),
        .count_spin(count_spin), .count_bit(count_bit), .count_iter(count_iter),
        .I0(I0), .Q(Q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                 rst_ini;
        logic                 rst_iter;
        logic                 en_read;
        logic                 en_mult;
        logic                 en_upd;
        logic                 wea;
        logic                 busy;
        logic                 done;
        logic [CW-1:0]        spin;
        logic [CW-1:0]        bit_idx;
        logic [15:0]          iter;
        logic signed [TW-1:0] i0;
        logic signed [TW-1:0] q;
    } obs_t;

    int            vectors = 0;
    int            miscompares = 0;
    obs_t          m;
    bit            m_last_idle;
    logic          p_we;
    logic [CW-1:0] p_spin;
    logic [CW-1:0] p_bit;

    function automatic obs_t sample();
        obs_t o;
        o.rst_ini = rst_ini;   o.rst_iter = rst_iter; o.en_read = en_read;
        o.en_mult = en_mult;   o.en_upd = en_upd;     o.wea = wea;
        o.busy = busy;         o.done = done;         o.spin = count_spin;
        o.bit_idx = count_bit; o.iter = count_iter;   o.i0 = I0;
        o.q = Q;
        return o;
    endfunction

    function automatic logic signed [TW-1:0] sched_i0(input int it);
        int v;
        v = I0_MIN + (it / TAU) * I0_STEP;
        if (v > I0_MAX) v = I0_MAX;
        return TW'(v);
    endfunction

    function automatic logic signed [TW-1:0] sched_q(input int it);
        int v;
        v = Q_MIN + (it / TAU) * Q_STEP;
        if (v > Q_MAX) v = Q_MAX;
        return TW'(v);
    endfunction

    task automatic model_reset();
        m = '0;
        m.i0 = TW'(I0_MIN);
        m.q = TW'(Q_MIN);
        m_last_idle = 1'b1;
    endtask

    // Idle cycle: forwards last cycle's host traffic only if last cycle was idle too
    task automatic model_idle(output obs_t e);
        e = '0;
        e.iter = m.iter;
        e.i0 = m.i0;
        e.q = m.q;
        if (m_last_idle) begin
            e.wea = p_we;
            e.spin = p_spin;
            e.bit_idx = p_bit;
        end else begin
            e.spin = m.spin;
            e.bit_idx = m.bit_idx;
        end
        m = e;
        m_last_idle = 1'b1;
    endtask

    // Cycle c (1 = INIT) of a run of niter iterations
    task automatic model_run(input int c, input int niter, output obs_t e);
        int k, it, r, s, ph;
        e = '0;
        e.busy = 1'b1;
        if (c == 1) begin
            e.rst_ini = 1'b1;
            e.wea = p_we;
            e.spin = p_spin;
            e.bit_idx = p_bit;
            e.iter = m.iter;
            e.i0 = m.i0;
            e.q = m.q;
        end else begin
            k = c - 2;
            it = k / P;
            r = k % P;
            if (it >= niter) begin
                e.done = 1'b1;
                e.spin = m.spin;
                e.bit_idx = m.bit_idx;
                e.iter = 16'(niter);
                e.i0 = sched_i0(niter);
                e.q = sched_q(niter);
            end else begin
                e.iter = 16'(it);
                e.i0 = sched_i0(it);
                e.q = sched_q(it);
                if (r == 0) begin
                    e.rst_iter = 1'b1;
                end else begin
                    s = (r - 1) / (NN + 2);
                    ph = (r - 1) % (NN + 2);
                    e.spin = CW'(s);
                    if (ph < NN) begin
                        e.en_read = 1'b1;
                        e.en_mult = (ph > 0);
                        e.bit_idx = CW'(ph);
                    end else if (ph == NN) begin
                        e.en_mult = 1'b1;
                        e.bit_idx = CW'(NN - 1);
                    end else begin
                        e.en_upd = 1'b1;
                        e.bit_idx = CW'(NN - 1);
                    end
                end
            end
        end
        m = e;
        m_last_idle = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit ab, input logic [15:0] ni);
        start = st;
        abort = ab;
        num_iter = st ? ni : 16'($urandom);
        ld_we = 1'($urandom_range(0, 1));
        ld_spin = CW'($urandom);
        ld_bit = CW'($urandom);
        p_we = ld_we;
        p_spin = ld_spin;
        p_bit = ld_bit;
    endtask

    task automatic test_reset();
        obs_t e, got;
        drive(1'b0, 1'b0, 16'd0);
        #12;
        e = '0;
        e.i0 = TW'(I0_MIN);
        e.q = TW'(Q_MIN);
        got = sample();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL reset: got %h expected %h", got, e);
        end
        model_reset();
        #8;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_host_load();
        obs_t e, got;
        for (int i = 0; i < 6; i++) begin
            tick();
            model_idle(e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL host_load i=%0d: got %h expected %h", i, got, e);
            end
            if (i == 3) begin
                vectors++;
                if ({got.wea, got.spin, got.bit_idx} !== {1'b1, 2'd3, 2'd1}) begin
                    miscompares++;
                    $display("[TB] FAIL host_load_fixed: got wea=%b spin=%0d bit=%0d expected 1/3/1",
                             got.wea, got.spin, got.bit_idx);
                end
            end
            drive(1'b0, 1'($urandom_range(0, 1)), 16'd0);
            if (i == 2) begin
                ld_we = 1'b1;   ld_spin = 2'd3; ld_bit = 2'd1;
                p_we = 1'b1;    p_spin = 2'd3;  p_bit = 2'd1;
            end
        end
    endtask

    task automatic test_full_run();
        obs_t e, got;
        int n_upd, n_iter, n_ini, done_c;
        logic [15:0] seq [3];
        n_upd = 0; n_iter = 0; n_ini = 0; done_c = -1;
        drive(1'b1, 1'($urandom_range(0, 1)), 16'd3);
        for (int c = 1; c <= 2 + 3 * P; c++) begin
            tick();
            model_run(c, 3, e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL full_run c=%0d: got %h expected %h", c, got, e);
            end
            if (c >= 3 && c <= 8) begin
                vectors++;
                if ({got.en_read, got.en_mult, got.en_upd} !== {c <= 6, c >= 4 && c <= 7, c == 8} ||
                    (c <= 6 && got.bit_idx !== CW'(c - 3))) begin
                    miscompares++;
                    $display("[TB] FAIL first_spin c=%0d: got rd=%b mult=%b upd=%b bit=%0d",
                             c, got.en_read, got.en_mult, got.en_upd, got.bit_idx);
                end
            end
            if (got.rst_iter === 1'b1 && n_iter < 3) seq[n_iter] = got.iter;
            n_upd += int'(got.en_upd === 1'b1);
            n_iter += int'(got.rst_iter === 1'b1);
            n_ini += int'(got.rst_ini === 1'b1);
            if (got.done === 1'b1) done_c = c;
            drive(1'($urandom_range(0, 1)), 1'b0, 16'd0);
        end
        tick();
        model_idle(e);
        got = sample();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL full_run_idle: got %h expected %h", got, e);
        end
        drive(1'b0, 1'b0, 16'd0);
        vectors++;
        if (n_upd != 12 || n_iter != 3 || n_ini != 1 || done_c != 77) begin
            miscompares++;
            $display("[TB] FAIL pulse_counts: got upd=%0d iter=%0d ini=%0d done@%0d expected 12/3/1/77",
                     n_upd, n_iter, n_ini, done_c);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (n_iter < 3 || seq[i] !== 16'(i)) begin
                miscompares++;
                $display("[TB] FAIL iter_seq[%0d]: got %0d expected %0d", i, seq[i], i);
            end
        end
    endtask

    task automatic test_zero_iter();
        obs_t e, got;
        drive(1'b1, 1'b0, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c <= 2) model_run(c, 0, e);
            else model_idle(e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL zero_iter c=%0d: got %h expected %h", c, got, e);
            end
            if (c == 2) begin
                vectors++;
                if (got.done !== 1'b1 || got.en_upd !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL zero_iter_done: got done=%b upd=%b expected 1/0", got.done, got.en_upd);
                end
            end
            drive(1'b0, 1'b0, 16'd0);
        end
    endtask

    task automatic test_schedule();
        obs_t e, got;
        int n;
        logic signed [TW-1:0] i0_tab [8];
        logic signed [TW-1:0] q_tab [8];
        i0_tab = '{8'sd1, 8'sd1, 8'sd3, 8'sd3, 8'sd5, 8'sd5, 8'sd6, 8'sd6};
        q_tab = '{8'sd120, 8'sd120, 8'sd125, 8'sd125, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
        n = 0;
        drive(1'b1, 1'b0, 16'd8);
        for (int c = 1; c <= 2 + 8 * P; c++) begin
            tick();
            model_run(c, 8, e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL schedule c=%0d: got %h expected %h", c, got, e);
            end
            if (got.rst_iter === 1'b1 && n < 8) begin
                vectors++;
                if (got.i0 !== i0_tab[n] || got.q !== q_tab[n]) begin
                    miscompares++;
                    $display("[TB] FAIL sched_table[%0d]: got I0=%0d Q=%0d expected %0d/%0d",
                             n, got.i0, got.q, i0_tab[n], q_tab[n]);
                end
                n++;
            end
            drive(1'($urandom_range(0, 1)), 1'b0, 16'd0);
        end
        tick();
        model_idle(e);
        got = sample();
        vectors++;
        if (got !== e || n != 8) begin
            miscompares++;
            $display("[TB] FAIL schedule_idle: got %h expected %h (iterations seen %0d)", got, e, n);
        end
        drive(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_abort();
        obs_t e, got;
        drive(1'b1, 1'b0, 16'd4);
        // abort lands in the 3rd READ cycle of the third iteration (I0 already stepped)
        for (int c = 1; c <= 55; c++) begin
            tick();
            model_run(c, 4, e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL pre_abort c=%0d: got %h expected %h", c, got, e);
            end
            drive(1'b0, c == 55, 16'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            model_idle(e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL post_abort i=%0d: got %h expected %h", i, got, e);
            end
            if (i == 0) begin
                vectors++;
                if ({got.busy, got.done, got.en_read, got.en_mult, got.en_upd} !== 5'b0) begin
                    miscompares++;
                    $display("[TB] FAIL abort_quiet: got busy/done/rd/mult/upd=%b expected 00000",
                             {got.busy, got.done, got.en_read, got.en_mult, got.en_upd});
                end
            end
            // start and abort together in IDLE: start must win
            drive(i == 2, 1'b1, 16'd2);
        end
        for (int c = 1; c <= 3 + 2 * P; c++) begin
            tick();
            if (c <= 2 + 2 * P) model_run(c, 2, e);
            else model_idle(e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL rerun c=%0d: got %h expected %h", c, got, e);
            end
            if (c == 2) begin
                vectors++;
                if (got.i0 !== 8'sd1) begin
                    miscompares++;
                    $display("[TB] FAIL rerun_i0: got %0d expected 1", got.i0);
                end
            end
            drive(1'b0, 1'b0, 16'd0);
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t e, got;
        drive(1'b1, 1'b0, 16'd2);
        for (int c = 1; c <= 8; c++) begin
            tick();
            model_run(c, 2, e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL pre_reset c=%0d: got %h expected %h", c, got, e);
            end
            drive(1'b0, 1'b0, 16'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        e = '0;
        e.i0 = TW'(I0_MIN);
        e.q = TW'(Q_MIN);
        got = sample();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h expected %h", got, e);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            model_idle(e);
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL post_reset i=%0d: got %h expected %h", i, got, e);
            end
            drive(1'b0, 1'b0, 16'd0);
        end
    endtask

    task automatic test_random();
        obs_t e, got;
        int niter, gap;
        for (int r = 0; r < 3; r++) begin
            gap = $urandom_range(1, 3);
            for (int i = 0; i < gap; i++) begin
                tick();
                model_idle(e);
                got = sample();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("[TB] FAIL random_idle r=%0d: got %h expected %h", r, got, e);
                end
                drive(1'b0, 1'($urandom_range(0, 1)), 16'd0);
            end
            niter = $urandom_range(1, 3);
            drive(1'b1, 1'($urandom_range(0, 1)), 16'(niter));
            for (int c = 1; c <= 3 + niter * P; c++) begin
                tick();
                if (c <= 2 + niter * P) model_run(c, niter, e);
                else model_idle(e);
                got = sample();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("[TB] FAIL random_run r=%0d c=%0d: got %h expected %h", r, c, got, e);
                end
                drive(c <= 2 + niter * P ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 16'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_full_run();
        test_zero_iter();
        test_schedule();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ssqa_ctrl.md
Name: ssqa_ctrl

Overview:
Sequencer for the replicated SSQA spin array (M trotter replicas, shared J/h/nrnd streams). It generates the phase enables (rst_ini, rst_iter, en_read, en_mult, en_upd), the spin/bit/iteration counters, and the annealing schedule for I0 and Q.
In IDLE it also muxes host J-memory load traffic onto wea/count_spin/count_bit.
Sits directly above the array and the shared xorshift, under a host start/done handshake.

Parameters:
N, 800, number of spins updated per iteration (count_spin range 0..N-1)
NN, 800, number of coupling terms accumulated per spin (count_bit range 0..NN-1); sets counter width $clog2(NN)
TEM_WIDTH, 8, signed width of I0 and Q
I0_MIN, 1, initial I0 (signed)
I0_MAX, 64, I0 saturation ceiling (signed)
I0_STEP, 1, I0 increment per schedule step
Q_MIN, 0, initial Q (signed)
Q_MAX, 64, Q saturation ceiling (signed)
Q_STEP, 1, Q increment per schedule step
TAU, 1, number of iterations per schedule step (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  terminate the run; returns to IDLE
num_iter  in  16  iteration count, latched on accepted start
ld_we  in  1  host J-memory write strobe (IDLE only)
ld_spin  in  $clog2(NN)  host load spin address
ld_bit  in  $clog2(NN)  host load bit address
rst_ini  out  1  array/xorshift initial reset pulse
rst_iter  out  1  per-iteration accumulator reset
en_read  out  1  memory read enable
en_mult  out  1  multiply/accumulate enable
en_upd  out  1  spin update enable; also steps the xorshift
wea  out  1  J-memory write enable
count_spin  out  $clog2(NN)  current spin index
count_bit  out  $clog2(NN)  current coupling index
count_iter  out  16  current iteration index
I0  out  signed TEM_WIDTH  annealing pseudo-temperature
Q  out  signed TEM_WIDTH  inter-replica coupling strength
busy  out  1  high in every state except IDLE
done  out  1  one-cycle run-complete pulse

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, every enable/strobe, counter, busy and done =0.
  - I0=I0_MIN, Q=Q_MIN.
- All outputs are registered. Each state's outputs are valid during the cycle the FSM occupies that state.
- IDLE:
  - wea=ld_we, count_spin=ld_spin, count_bit=ld_bit, registered with one-cycle latency.
  - All other enables are 0.
  - start=1 latches num_iter and moves to INIT. An ld_we in the same cycle as start is still forwarded.
- INIT (1 cycle):
  - rst_ini=1.
  - I0<=I0_MIN, Q<=Q_MIN, count_iter<=0, schedule counter<=0.
  - num_iter==0 -> DONE, else -> ITER.
- ITER (1 cycle): rst_iter=1, count_spin=0, count_bit=0.
- READ (NN cycles):
  - en_read=1, count_bit steps 0..NN-1.
  - en_mult is en_read delayed by one cycle, so it is high from the 2nd READ cycle through DRAIN.
- DRAIN (1 cycle): en_read=0, en_mult=1, count_bit holds NN-1.
- UPD (1 cycle): en_upd=1.
  - count_spin<N-1 -> count_spin+1, count_bit=0, -> READ.
  - Else, at end of iteration:
    - count_iter+1; if count_iter+1==num_iter -> DONE, else -> ITER.
- DONE (1 cycle): done=1, -> IDLE. count_iter holds its final value until the next INIT.
- Timing:
  - Cycles per spin = NN+2.
  - Cycles per iteration = 1+N*(NN+2).
  - With start accepted at cycle 0, done is high at cycle 2+num_iter*(1+N*(NN+2)).
- Schedule:
  - Updates only at end-of-iteration UPD, so I0/Q are constant within an iteration.
  - The schedule counter counts iterations. When it reaches TAU-1 it wraps to 0 and applies the step:
    - I0<=min(I0+I0_STEP, I0_MAX)
    - Q<=min(Q+Q_STEP, Q_MAX)
  - Both sums are computed at TEM_WIDTH+1 bits, so the result saturates and never wraps.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE; all enables 0, done not asserted.
  - Counters and I0/Q hold.
  - An en_mult still in flight is cancelled.
- Ignored inputs:
  - start while busy is ignored.
  - abort in IDLE is ignored.
  - If abort and start arrive together in IDLE, start wins.
- Reset asserted mid-run: immediate return to reset values; no done pulse.
- Invariant: at most one of rst_ini, rst_iter, en_read, en_upd is high in any cycle.

Test Plan:
- N=4, NN=4, num_iter=3, start at cycle 0 -> done at cycle 77 only. Bench checks:
  - 12 en_upd pulses, 3 rst_iter pulses, 1 rst_ini.
  - count_iter sequence 0,1,2.
- One spin, NN=4 -> en_read on 4 cycles with count_bit 0,1,2,3; en_mult on the following 4 cycles; en_upd on the next cycle.
- I0_MIN=1, I0_STEP=2, I0_MAX=6, TAU=1, num_iter=5 -> I0 per iteration 1,3,5,6,6; Q ramps and saturates likewise.
- TAU=2, I0_STEP=1, num_iter=4 -> I0 per iteration 1,1,2,2.
- abort in the 3rd READ cycle of iteration 1 -> next cycle IDLE, busy=0, en_* =0, no done. A following start reruns from INIT with I0=I0_MIN.
- IDLE host load: ld_we=1, ld_spin=5, ld_bit=9 -> next cycle wea=1, count_spin=5, count_bit=9.
- num_iter=0 -> INIT then DONE (done at cycle 2), no en_upd.
- rst_n low during UPD -> all outputs 0 and I0=I0_MIN asynchronously.
